// File: rtl/fmdll_lock_det.sv
// -----------------------------------------------------------------------------
// fmdll_lock_det
//   Lock detector for the frequency-multiplying DLL. It watches the delay-line
//   control code Q on every CLK_exit edge. Lock is declared once Q has stayed
//   within +/-TOL of an anchor code for LOCK_CNT consecutive samples. Lock is
//   dropped after UNLOCK_CNT consecutive out-of-window samples. If lock is not
//   reached within TIMEOUT acquisition cycles, the block enters FAIL.
//
//   Optional feature macro: FMDLL_LOCK_TRACK_EN
//     defined   -> in LOCK, each in-window sample refreshes code_locked, so the
//                  window follows slow drift.
//     undefined -> code_locked is frozen for the whole LOCK residency.
//
// Ports
//   CLK_exit    in   1       reference clock (only clock)
//   rst_n       in   1       asynchronous active-low reset
//   en          in   1       enable; low returns the block to IDLE
//   Q           in   CODE_W  control code, synchronous to CLK_exit
//   locked      out  1       lock indication (registered)
//   lock_fail   out  1       acquisition timeout, sticky while en is high
//   state       out  2       IDLE=00 ACQ=01 LOCK=10 FAIL=11
//   code_locked out  CODE_W  reference code held while in LOCK
//   unlock_evt  out  1       one-cycle pulse on each LOCK->ACQ transition
// -----------------------------------------------------------------------------
module fmdll_lock_det #(
  parameter int CODE_W     = 10,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              CLK_exit,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CODE_W-1:0] Q,
  output logic              locked,
  output logic              lock_fail,
  output logic [1:0]        state,
  output logic [CODE_W-1:0] code_locked,
  output logic              unlock_evt
);

  // Counter widths: each limit fits with one spare bit so limit itself is
  // representable and saturation never aliases onto a compare value.
  localparam int SW = $clog2(LOCK_CNT) + 1;
  localparam int MW = $clog2(UNLOCK_CNT) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [SW-1:0]   LOCK_CNT_C   = SW'(LOCK_CNT);
  localparam logic [MW-1:0]   UNLOCK_CNT_C = MW'(UNLOCK_CNT);
  localparam logic [TW-1:0]   TIMEOUT_C    = TW'(TIMEOUT);
  localparam logic [CODE_W:0] TOL_C        = (CODE_W + 1)'(TOL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACQ  = 2'b01,
    ST_LOCK = 2'b10,
    ST_FAIL = 2'b11
  } state_t;

  // Absolute difference with one extra bit so 0x000 vs 0x3FF does not wrap.
  function automatic logic [CODE_W:0] abs_diff(input logic [CODE_W-1:0] a,
                                               input logic [CODE_W-1:0] b);
    logic [CODE_W:0] ea;
    logic [CODE_W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    if (ea >= eb) begin
      abs_diff = ea - eb;
    end else begin
      abs_diff = eb - ea;
    end
  endfunction

  state_t            state_r, state_nx;
  logic [CODE_W-1:0] ref_r, ref_nx;
  logic [CODE_W-1:0] code_r, code_nx;
  logic [SW-1:0]     stab_r, stab_nx, stab_inc_s;
  logic [MW-1:0]     miss_r, miss_nx, miss_inc_s;
  logic [TW-1:0]     tmo_r, tmo_nx, tmo_inc_s;
  logic              locked_r, locked_nx;
  logic              fail_r, fail_nx;
  logic              evt_r, evt_nx;
  logic [CODE_W-1:0] cmp_s;
  logic              in_win_s;

  // Window test: ACQ compares against the anchor, LOCK against the locked code.
  always_comb begin
    cmp_s = ref_r;
    if (state_r == ST_LOCK) begin
      cmp_s = code_r;
    end else begin
      cmp_s = ref_r;
    end
    in_win_s   = (abs_diff(Q, cmp_s) <= TOL_C);
    stab_inc_s = (&stab_r) ? stab_r : stab_r + SW'(1);
    miss_inc_s = (&miss_r) ? miss_r : miss_r + MW'(1);
    tmo_inc_s  = (&tmo_r)  ? tmo_r  : tmo_r  + TW'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx  = state_r;
    ref_nx    = ref_r;
    code_nx   = code_r;
    stab_nx   = stab_r;
    miss_nx   = miss_r;
    tmo_nx    = tmo_r;
    locked_nx = locked_r;
    fail_nx   = fail_r;
    evt_nx    = 1'b0;

    if (!en) begin
      state_nx  = ST_IDLE;
      ref_nx    = '0;
      code_nx   = '0;
      stab_nx   = '0;
      miss_nx   = '0;
      tmo_nx    = '0;
      locked_nx = 1'b0;
      fail_nx   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx = ST_ACQ;
          ref_nx   = Q;
          stab_nx  = '0;
          tmo_nx   = '0;
          miss_nx  = '0;
        end
        ST_ACQ: begin
          tmo_nx = tmo_inc_s;
          if (in_win_s) begin
            stab_nx = stab_inc_s;
          end else begin
            stab_nx = '0;
            ref_nx  = Q;
          end
          // Lock takes priority over a simultaneous timeout.
          if (in_win_s && (stab_inc_s == LOCK_CNT_C)) begin
            state_nx  = ST_LOCK;
            locked_nx = 1'b1;
            code_nx   = Q;
            miss_nx   = '0;
          end else if (tmo_inc_s == TIMEOUT_C) begin
            state_nx = ST_FAIL;
            fail_nx  = 1'b1;
          end else begin
            state_nx = ST_ACQ;
          end
        end
        ST_LOCK: begin
          if (in_win_s) begin
            miss_nx = '0;
`ifdef FMDLL_LOCK_TRACK_EN
            code_nx = Q;
`else
            code_nx = code_r;
`endif
          end else if (miss_inc_s == UNLOCK_CNT_C) begin
            state_nx  = ST_ACQ;
            locked_nx = 1'b0;
            evt_nx    = 1'b1;
            ref_nx    = Q;
            stab_nx   = '0;
            tmo_nx    = '0;
            miss_nx   = '0;
          end else begin
            miss_nx = miss_inc_s;
          end
        end
        ST_FAIL: begin
          fail_nx = 1'b1;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_exit or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ref_r    <= '0;
      code_r   <= '0;
      stab_r   <= '0;
      miss_r   <= '0;
      tmo_r    <= '0;
      locked_r <= 1'b0;
      fail_r   <= 1'b0;
      evt_r    <= 1'b0;
    end else begin
      state_r  <= state_nx;
      ref_r    <= ref_nx;
      code_r   <= code_nx;
      stab_r   <= stab_nx;
      miss_r   <= miss_nx;
      tmo_r    <= tmo_nx;
      locked_r <= locked_nx;
      fail_r   <= fail_nx;
      evt_r    <= evt_nx;
    end
  end

  assign state       = state_r;
  assign locked      = locked_r;
  assign lock_fail   = fail_r;
  assign code_locked = code_r;
  assign unlock_evt  = evt_r;

endmodule

// File: tb/tb_fmdll_lock_det.sv
// -----------------------------------------------------------------------------
// tb_fmdll_lock_det
//   Self-checking bench for fmdll_lock_det with default parameters. A
//   behavioural model tracks the detector with plain integers and is compared
//   against every DUT output one time unit after each clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fmdll_lock_det;

  localparam int CODE_W     = 10;
  localparam int TOL        = 1;
  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_CNT = 4;
  localparam int TIMEOUT    = 1023;

  logic              clk_s = 1'b0;
  logic              rst_n_s;
  logic              en_s;
  logic [CODE_W-1:0] q_s;
  logic              locked_s;
  logic              lock_fail_s;
  logic [1:0]        state_s;
  logic [CODE_W-1:0] code_locked_s;
  logic              unlock_evt_s;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state (0 IDLE, 1 ACQ, 2 LOCK, 3 FAIL).
  int m_st, m_ref, m_code, m_stab, m_tmo, m_miss;
  int m_locked, m_fail, m_evt;

  fmdll_lock_det #(
    .CODE_W(CODE_W), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_exit   (clk_s),
    .rst_n      (rst_n_s),
    .en         (en_s),
    .Q          (q_s),
    .locked     (locked_s),
    .lock_fail  (lock_fail_s),
    .state      (state_s),
    .code_locked(code_locked_s),
    .unlock_evt (unlock_evt_s)
  );

  // Reference clock.
  always #5 clk_s = ~clk_s;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ref = 0; m_code = 0; m_stab = 0; m_tmo = 0; m_miss = 0;
    m_locked = 0; m_fail = 0; m_evt = 0;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One reference-clock edge of the detector, straight from its rules.
  task automatic model_edge(input int e, input int q);
    m_evt = 0;
    if (e == 0) begin
      model_reset();
      return;
    end
    case (m_st)
      0: begin
        m_st = 1; m_ref = q; m_stab = 0; m_tmo = 0;
      end
      1: begin
        m_tmo++;
        if (iabs(q - m_ref) <= TOL) begin
          m_stab++;
        end else begin
          m_stab = 0;
          m_ref  = q;
        end
        if (m_stab == LOCK_CNT) begin
          m_st = 2; m_locked = 1; m_code = q; m_miss = 0;
        end else if (m_tmo == TIMEOUT) begin
          m_st = 3; m_fail = 1;
        end
      end
      2: begin
        if (iabs(q - m_code) <= TOL) begin
          m_miss = 0;
`ifdef FMDLL_LOCK_TRACK_EN
          m_code = q;
`endif
        end else begin
          m_miss++;
          if (m_miss == UNLOCK_CNT) begin
            m_st = 1; m_locked = 0; m_evt = 1; m_ref = q;
            m_stab = 0; m_tmo = 0; m_miss = 0;
          end
        end
      end
      default: begin
        m_fail = 1;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},     int'(state_s),      m_st);
    chk({tag, ".locked"},    int'(locked_s),     m_locked);
    chk({tag, ".lock_fail"}, int'(lock_fail_s),  m_fail);
    chk({tag, ".evt"},       int'(unlock_evt_s), m_evt);
    // code_locked is defined while locked and cleared in IDLE.
    if (m_st == 2 || m_st == 0) begin
      chk({tag, ".code"}, int'(code_locked_s), m_code);
    end
  endtask

  // Drive one cycle of stimulus, advance model, check outputs after the edge.
  task automatic step(input string tag, input int e, input int q);
    en_s = e[0];
    q_s  = q[CODE_W-1:0];
    @(posedge clk_s);
    model_edge(e, q & 32'h3FF);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset a little after an edge; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    rst_n_s = 1'b0;
    #1;
    model_reset();
    chk({tag, ".state"},  int'(state_s),       0);
    chk({tag, ".locked"}, int'(locked_s),      0);
    chk({tag, ".fail"},   int'(lock_fail_s),   0);
    chk({tag, ".evt"},    int'(unlock_evt_s),  0);
    chk({tag, ".code"},   int'(code_locked_s), 0);
    @(negedge clk_s);
    rst_n_s = 1'b1;
  endtask

  initial begin
    int base;
    int q;
    int e;
    rst_n_s = 1'b0;
    en_s    = 1'b0;
    q_s     = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk_s);
    rst_n_s = 1'b1;
    step("idle", 0, 0);

    // Constant code: 16 ACQ edges after the capture edge, then lock.
    for (int i = 0; i < 17; i++) step("c155", 1, 'h155);
    chk("c155.locked_after_k16", int'(locked_s), 1);
    chk("c155.code_after_k16", int'(code_locked_s), 'h155);
    for (int i = 0; i < 4; i++) step("c155h", 1, 'h155);

    // Alternating code never settles; timeout then en drop.
    step("alt_off", 0, 0);
    for (int i = 0; i < 1030; i++) step("alt", 1, (i % 2 == 0) ? 'h100 : 'h103);
    chk("alt.fail_state", int'(state_s), 3);
    step("alt_drop", 0, 'h100);
    chk("alt.fail_cleared", int'(lock_fail_s), 0);

    // Lock at 0x200, short excursion, then a full unlock.
    for (int i = 0; i < 18; i++) step("l200", 1, 'h200);
    for (int i = 0; i < 3; i++)  step("exc3", 1, 'h205);
    for (int i = 0; i < 2; i++)  step("back", 1, 'h200);
    for (int i = 0; i < 4; i++)  step("exc4", 1, 'h205);
    chk("exc4.evt", int'(unlock_evt_s), 1);
    for (int i = 0; i < 3; i++)  step("post", 1, 'h205);

    // Slow ramp from a fresh lock at 0x200.
    step("ramp_off", 0, 0);
    for (int i = 0; i < 18; i++) step("ramp_lock", 1, 'h200);
    for (int v = 0; v <= 8; v++) begin
      for (int i = 0; i < 20; i++) step("ramp", 1, 'h200 + v);
    end

    // Boundary: no wrap between 0x000 and 0x3FF; 0x3FE is one away.
    step("bnd_off", 0, 0);
    step("bnd_anchor", 1, 'h3FF);
    step("bnd_wrap", 1, 'h000);
    step("bnd_anchor2", 1, 'h3FF);
    for (int i = 0; i < 18; i++) step("bnd_near", 1, (i % 2 == 0) ? 'h3FE : 'h3FF);

    // Reset mid-ACQ, then while locked; relock latency must be 17 edges.
    step("rst_off", 0, 0);
    for (int i = 0; i < 6; i++) step("rst_acq", 1, 'h0AA);
    async_reset("rst_acq_async");
    for (int i = 0; i < 20; i++) step("rst_relock", 1, 'h0AA);
    async_reset("rst_lock_async");
    for (int i = 0; i < 16; i++) step("rst_relock2", 1, 'h0AA);
    chk("rst.not_yet_locked", int'(locked_s), 0);
    step("rst_relock2", 1, 'h0AA);
    chk("rst.locked_at_17", int'(locked_s), 1);

    // Randomized walk around a base code with occasional jumps and en drops.
    base = 'h1F0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) base = int'($urandom_range(0, 1023));
      e = ($urandom_range(0, 149) == 0) ? 0 : 1;
      q = (base + int'($urandom_range(0, 4)) - 2) & 'h3FF;
      if ($urandom_range(0, 3) != 0) q = base;
      step("rand", e, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
